// File: rtl/cv_pkg.sv
// Shared definitions for the CV tile scheduler.
// Holds the dimension widths, the scheduler state encoding, the latched
// layer configuration record and a zero-extension helper used wherever
// 11-bit dimensions are combined at the 12-bit internal width.
package cv_pkg;

  localparam int DIM_W = 11;          // width of every layer/tile dimension
  localparam int INT_W = DIM_W + 1;   // internal width so origin + tile never wraps
  localparam int K_W   = 5;           // kernel size width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LW   = 3'd1,
    LIF  = 3'd2,
    SOF  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_e;

  // Configuration captured on an accepted start.
  typedef struct packed {
    logic [DIM_W-1:0] i;
    logic [DIM_W-1:0] o;
    logic [DIM_W-1:0] ho;
    logic [DIM_W-1:0] wo;
    logic [K_W-1:0]   k;
    logic [DIM_W-1:0] tile_o;
    logic [DIM_W-1:0] tile_h;
    logic [DIM_W-1:0] tile_w;
  } cfg_t;

  function automatic logic [INT_W-1:0] zx(input logic [DIM_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/cv_tile_scheduler_if.sv
// Scheduler <-> data loader interface.
// master (scheduler): drives tile origins/extents and the three level
//   commands load_weight/load_input/store_output; receives loader_done.
// slave (loader): the mirror view; drives the one-cycle loader_done pulse.
interface cv_tile_scheduler_if;
  import cv_pkg::*;

  logic [DIM_W-1:0] Iori, Oori, Hori, Wori;
  logic [DIM_W-1:0] Iext, Oext, Hext, Wext;
  logic             load_weight, load_input, store_output;
  logic             loader_done;

  modport master (
    output Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
    output load_weight, load_input, store_output,
    input  loader_done
  );

  modport slave (
    input  Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
    input  load_weight, load_input, store_output,
    output loader_done
  );
endinterface

// File: rtl/cv_tile_extent.sv
// Tile extent along one axis.
// Ports: tile  - maximum tile size on this axis
//        total - full output size on this axis
//        ori   - current tile origin
//        k     - kernel size (used only when HALO is set)
//        ext   - min(tile, total - ori), plus k-1 halo pixels when HALO=1
module cv_tile_extent
  import cv_pkg::*;
#(
  parameter bit HALO = 1'b0
) (
  input  logic [DIM_W-1:0] tile,
  input  logic [DIM_W-1:0] total,
  input  logic [DIM_W-1:0] ori,
  input  logic [K_W-1:0]   k,
  output logic [DIM_W-1:0] ext
);

  logic [INT_W-1:0] rem, span, halo, sum;
  logic             unused_sum_msb;

  assign rem  = zx(total) - zx(ori);
  assign span = (zx(tile) < rem) ? zx(tile) : rem;
  assign halo = HALO ? (INT_W'(k) - INT_W'(1)) : '0;
  assign sum  = span + halo;

  // For a valid layer span + k - 1 never exceeds H (or W), so the top bit is zero.
  assign ext            = sum[DIM_W-1:0];
  assign unused_sum_msb = sum[INT_W-1];

endmodule

// File: rtl/cv_tile_scheduler.sv
// Convolution layer tile scheduler.
// Walks a layer as output-channel tiles (outer), output rows, output cols
// (inner), issuing load_weight once per O tile and load_input/store_output
// for every spatial tile, each held until the loader reports done.
// Ports: clk, rst_n (async active-low); start + I/O/H/W/K/TO/TH/TW layer
//        configuration; ldr (loader interface, master side);
//        busy, done (pulse), err (sticky), tiles (completed spatial tiles).
module cv_tile_scheduler
  import cv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIM_W-1:0]           I,
  input  logic [DIM_W-1:0]           O,
  input  logic [DIM_W-1:0]           H,
  input  logic [DIM_W-1:0]           W,
  input  logic [K_W-1:0]             K,
  input  logic [DIM_W-1:0]           TO,
  input  logic [DIM_W-1:0]           TH,
  input  logic [DIM_W-1:0]           TW,
  cv_tile_scheduler_if.master        ldr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [15:0]                tiles
);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [DIM_W-1:0] oori_q, oori_d, hori_q, hori_d, wori_q, wori_d;
  logic             err_q, err_d;
  logic [15:0]      tiles_q, tiles_d;
  logic [INT_W-1:0] w_adv, h_adv, o_adv;
  logic [DIM_W-1:0] oext, hext, wext;
  logic             cfg_bad, show;

  assign cfg_bad = (K == '0) || (DIM_W'(K) > H) || (DIM_W'(K) > W) ||
                   (TO == '0) || (TH == '0) || (TW == '0);

  assign w_adv = zx(wori_q) + zx(cfg_q.tile_w);
  assign h_adv = zx(hori_q) + zx(cfg_q.tile_h);
  assign o_adv = zx(oori_q) + zx(cfg_q.tile_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      oori_q  <= '0;
      hori_q  <= '0;
      wori_q  <= '0;
      err_q   <= 1'b0;
      tiles_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      oori_q  <= oori_d;
      hori_q  <= hori_d;
      wori_q  <= wori_d;
      err_q   <= err_d;
      tiles_q <= tiles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    oori_d  = oori_q;
    hori_d  = hori_q;
    wori_d  = wori_q;
    err_d   = err_q;
    tiles_d = tiles_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d.i      = I;
          cfg_d.o      = O;
          cfg_d.ho     = H - DIM_W'(K) + DIM_W'(1);
          cfg_d.wo     = W - DIM_W'(K) + DIM_W'(1);
          cfg_d.k      = K;
          cfg_d.tile_o = TO;
          cfg_d.tile_h = TH;
          cfg_d.tile_w = TW;
          oori_d       = '0;
          hori_d       = '0;
          wori_d       = '0;
          tiles_d      = '0;
          err_d        = cfg_bad;
          // A bad configuration goes straight to DONE so no command is issued.
          state_d      = cfg_bad ? DONE : LW;
        end
      end
      LW:  if (ldr.loader_done) state_d = LIF;
      LIF: if (ldr.loader_done) state_d = SOF;
      SOF: if (ldr.loader_done) state_d = NEXT;
      NEXT: begin
        tiles_d = tiles_q + 16'd1;
        if (w_adv < zx(cfg_q.wo)) begin
          wori_d  = w_adv[DIM_W-1:0];
          state_d = LIF;
        end else begin
          wori_d = '0;
          if (h_adv < zx(cfg_q.ho)) begin
            hori_d  = h_adv[DIM_W-1:0];
            state_d = LIF;
          end else begin
            hori_d = '0;
            if (o_adv >= zx(cfg_q.o)) begin
              state_d = DONE;
            end else begin
              oori_d  = o_adv[DIM_W-1:0];
              state_d = LW;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  cv_tile_extent #(.HALO(1'b0)) u_ext_o (
    .tile(cfg_q.tile_o), .total(cfg_q.o),  .ori(oori_q), .k(cfg_q.k), .ext(oext)
  );
  cv_tile_extent #(.HALO(1'b1)) u_ext_h (
    .tile(cfg_q.tile_h), .total(cfg_q.ho), .ori(hori_q), .k(cfg_q.k), .ext(hext)
  );
  cv_tile_extent #(.HALO(1'b1)) u_ext_w (
    .tile(cfg_q.tile_w), .total(cfg_q.wo), .ori(wori_q), .k(cfg_q.k), .ext(wext)
  );

  // Extents are only meaningful while a layer is being walked; outside that
  // they read zero so a bad or stale configuration never leaks out.
  assign show = (state_q == LW) || (state_q == LIF) ||
                (state_q == SOF) || (state_q == NEXT);

  assign ldr.load_weight  = (state_q == LW);
  assign ldr.load_input   = (state_q == LIF);
  assign ldr.store_output = (state_q == SOF);
  assign ldr.Iori         = '0;
  assign ldr.Oori         = oori_q;
  assign ldr.Hori         = hori_q;
  assign ldr.Wori         = wori_q;
  assign ldr.Iext         = show ? cfg_q.i : '0;
  assign ldr.Oext         = show ? oext : '0;
  assign ldr.Hext         = show ? hext : '0;
  assign ldr.Wext         = show ? wext : '0;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign tiles = tiles_q;

endmodule
